// File: rtl/dyn_delay_ctrl.sv
// dyn_delay_ctrl: sequences IDELAYE2 VAR_LOAD_PIPE loads per channel and keeps a shadow tap for each.
module dyn_delay_ctrl #(
  parameter int N_CH       = 4,
  parameter int TAP_W      = 5,
  parameter int SETTLE_CYC = 8,
  parameter int WRAP       = 0,
  parameter int CH_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dly_rdy,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CH_W-1:0]        cmd_ch,
  input  logic [TAP_W-1:0]       cmd_val,
  output logic                   done,
  output logic                   sat,
  output logic                   err,
  output logic                   busy,
  output logic [N_CH*TAP_W-1:0]  tap_cur,
  output logic [N_CH*TAP_W-1:0]  idl_cntvalue,
  output logic [N_CH-1:0]        idl_ldpipeen,
  output logic [N_CH-1:0]        idl_ld
);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam int IDX_W = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic [2:0] {S_WAIT, S_IDLE, S_PIPE, S_LOAD, S_SETTLE, S_DONE} state_t;
  state_t state_q;
  logic [N_CH-1:0][TAP_W-1:0] tap_q, cnt_q;
  logic [N_CH-1:0] lpe_q, ld_q;
  logic [IDX_W-1:0] ch_q, ch_d;
  logic [TAP_W-1:0] new_tap_q, new_tap_d;
  logic [CNT_W-1:0] settle_q;
  logic [TAP_W:0] sum_d, dif_d;
  logic all_q, sat_d, satr_q, rdy_q, done_q, sat_q, err_q, busy_q, bad_ch, accept;
  always_comb begin
    ch_d      = IDX_W'(cmd_ch);
    sum_d     = {1'b0, tap_q[ch_d]} + {1'b0, cmd_val};
    dif_d     = {1'b0, tap_q[ch_d]} - {1'b0, cmd_val};
    new_tap_d = cmd_op == 2'b01 ? (sum_d[TAP_W] && WRAP == 0 ? '1 : sum_d[TAP_W-1:0]) :
                cmd_op == 2'b10 ? (dif_d[TAP_W] && WRAP == 0 ? '0 : dif_d[TAP_W-1:0]) : cmd_val;
    sat_d     = (cmd_op == 2'b01 && sum_d[TAP_W]) || (cmd_op == 2'b10 && dif_d[TAP_W]);
    bad_ch    = cmd_op != 2'b11 && 32'(cmd_ch) >= N_CH;
    accept    = cmd_valid && rdy_q;
  end
  // Status outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      tap_q     <= '0;
      cnt_q     <= '0;
      lpe_q     <= '0;
      ld_q      <= '0;
      ch_q      <= '0;
      new_tap_q <= '0;
      settle_q  <= '0;
      all_q     <= 1'b0;
      satr_q    <= 1'b0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      lpe_q  <= '0;
      ld_q   <= '0;
      done_q <= state_q == S_DONE;
      sat_q  <= state_q == S_DONE && satr_q;
      busy_q <= !(state_q inside {S_IDLE, S_WAIT});
      rdy_q  <= state_q == S_IDLE && dly_rdy && !accept;
      case (state_q)
        S_WAIT: if (dly_rdy) state_q <= S_IDLE;
        S_IDLE:
          if (accept) begin
            all_q     <= cmd_op == 2'b11;
            ch_q      <= cmd_op == 2'b11 ? '0 : ch_d;
            new_tap_q <= new_tap_d;
            satr_q    <= sat_d && !bad_ch;
            err_q     <= err_q && bad_ch;
            state_q   <= bad_ch ? S_DONE : S_PIPE;
          end else if (!dly_rdy) state_q <= S_WAIT;
        S_PIPE:
          if (!dly_rdy) begin
            err_q   <= 1'b1;
            state_q <= S_WAIT;
          end else begin
            cnt_q[ch_q] <= new_tap_q;
            lpe_q[ch_q] <= 1'b1;
            state_q     <= S_LOAD;
          end
        S_LOAD:
          if (!dly_rdy) begin
            err_q   <= 1'b1;
            state_q <= S_WAIT;
          end else begin
            ld_q[ch_q]  <= 1'b1;
            tap_q[ch_q] <= new_tap_q;
            if (all_q && ch_q != IDX_W'(N_CH - 1)) begin
              ch_q    <= ch_q + IDX_W'(1);
              state_q <= S_PIPE;
            end else begin
              settle_q <= '0;
              state_q  <= S_SETTLE;
            end
          end
        S_SETTLE:
          if (!dly_rdy) begin
            err_q   <= 1'b1;
            state_q <= S_WAIT;
          end else if (settle_q == CNT_W'(SETTLE_CYC - 1)) state_q <= S_DONE;
          else settle_q <= settle_q + CNT_W'(1);
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_WAIT;
      endcase
    end
  end
  assign cmd_ready    = rdy_q;
  assign done         = done_q;
  assign sat          = sat_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign tap_cur      = tap_q;
  assign idl_cntvalue = cnt_q;
  assign idl_ldpipeen = lpe_q;
  assign idl_ld       = ld_q;
endmodule

// File: tb/tb_dyn_delay_ctrl.sv
// tb_dyn_delay_ctrl: random and directed commands against saturating and wrapping instances, scoreboarded.
module tb_dyn_delay_ctrl;
  localparam int N = 4, TW = 5, S = 8;
  typedef struct { int cyc; int ch; bit ld; int v0; int v1; } pin_t;
  typedef struct { int cyc; bit s0; bit s1; bit e; logic [N*TW-1:0] t0; logic [N*TW-1:0] t1; } dn_t;
  logic clk = 0, rst_n = 0, dly_rdy = 0, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_ch = 0;
  logic [TW-1:0] cmd_val = 0;
  logic rdy0, done0, sat0, err0, busy0, rdy1, done1, sat1, err1, busy1;
  logic [N*TW-1:0] tap0, cnt0, tap1, cnt1;
  logic [N-1:0] lpe0, ld0, lpe1, ld1;
  int cyc = 0, checks = 0, failures = 0;
  int mt0[N] = '{default: 0}, mt1[N] = '{default: 0};
  bit merr = 0;
  pin_t pin_q[$];
  dn_t dq[$];
  dyn_delay_ctrl #(.N_CH(N), .TAP_W(TW), .SETTLE_CYC(S), .WRAP(0), .CH_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .dly_rdy(dly_rdy), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_val(cmd_val), .done(done0), .sat(sat0), .err(err0),
    .busy(busy0), .tap_cur(tap0), .idl_cntvalue(cnt0), .idl_ldpipeen(lpe0), .idl_ld(ld0));
  dyn_delay_ctrl #(.N_CH(N), .TAP_W(TW), .SETTLE_CYC(S), .WRAP(1), .CH_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .dly_rdy(dly_rdy), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_val(cmd_val), .done(done1), .sat(sat1), .err(err1),
    .busy(busy1), .tap_cur(tap1), .idl_cntvalue(cnt1), .idl_ldpipeen(lpe1), .idl_ld(ld1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #300000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [N*TW-1:0] pack(input int m[N]);
    logic [N*TW-1:0] r;
    for (int k = 0; k < N; k++) r[k*TW +: TW] = TW'(m[k]);
    return r;
  endfunction
  function automatic int nt(input int t, input int op, input int v, input bit w, output bit s);
    int r;
    r = op == 1 ? t + v : op == 2 ? t - v : v;
    s = r > 31 || r < 0;
    return !s ? r : w ? (r + 32) % 32 : (r < 0 ? 0 : 31);
  endfunction
  task automatic wait_ready();
    int t = 0;
    while (!(rdy0 && rdy1) && t <= 200) begin
      @(negedge clk);
      t++;
    end
    if (t > 200) chk("ready_timeout", 128'(t), 0);
  endtask
  task automatic ready_rise();
    @(negedge clk);
    chk("ready_early", {rdy0, rdy1}, 2'b00);
    @(negedge clk);
    chk("ready_rise", {rdy0, rdy1}, 2'b11);
  endtask
  task automatic issue(input int op, input int ch, input int val, input int abort_k, input bit poke);
    int a, n0, n1, nch;
    bit s0 = 0, s1 = 0, bad;
    wait_ready();
    cmd_valid = 1;
    cmd_op = 2'(op);
    cmd_ch = 3'(ch);
    cmd_val = TW'(val);
    a = cyc + 1;
    @(negedge clk);
    cmd_valid = 0;
    bad = op != 3 && ch >= N;
    if (op == 3) begin
      nch = abort_k < 0 ? N : abort_k;
      for (int k = 0; k < nch; k++) begin
        mt0[k] = val;
        mt1[k] = val;
        pin_q.push_back('{a + 1 + 2*k, k, 1'b0, val, val});
        pin_q.push_back('{a + 2 + 2*k, k, 1'b1, val, val});
      end
    end else if (!bad) begin
      n0 = nt(mt0[ch], op, val, 0, s0);
      n1 = nt(mt1[ch], op, val, 1, s1);
      mt0[ch] = n0;
      mt1[ch] = n1;
      pin_q.push_back('{a + 1, ch, 1'b0, n0, n1});
      pin_q.push_back('{a + 2, ch, 1'b1, n0, n1});
    end
    if (!bad) merr = 0;
    if (abort_k < 0)
      dq.push_back('{bad ? a + 1 : op == 3 ? a + 2*N + 1 + S : a + 3 + S, s0, s1, merr, pack(mt0), pack(mt1)});
    if (poke) begin
      cmd_valid = 1;
      cmd_op = 2'($urandom_range(0, 3));
      cmd_ch = 0;
      @(negedge clk);
      chk("busy_window", {busy0, busy1, rdy0, rdy1}, 4'b1100);
      if (!bad) repeat (2) @(negedge clk);
      cmd_valid = 0;
    end
    if (abort_k >= 0) begin
      while (cyc < a + 2*abort_k) @(negedge clk);
      dly_rdy = 0;
      merr = 1;
      repeat (4) @(negedge clk);
      chk("abort_flags", {err0, err1, busy0, busy1, rdy0, rdy1}, 6'b110000);
      chk("abort_taps", {tap0, tap1}, {pack(mt0), pack(mt1)});
      dly_rdy = 1;
    end
  endtask
  always @(negedge clk) begin
    pin_t e;
    dn_t d;
    logic [3:0] m;
    if (rst_n) begin
      if (pin_q.size() > 0 && pin_q[0].cyc < cyc) begin
        e = pin_q.pop_front();
        chk("pin_missing", 128'(cyc), 128'(e.cyc));
      end
      if ((lpe0 | ld0 | lpe1 | ld1) != 0) begin
        if (pin_q.size() == 0) chk("pin_unexpected", {lpe0, ld0, lpe1, ld1}, 0);
        else begin
          e = pin_q.pop_front();
          m = 4'(1 << e.ch);
          chk("pin", {cyc, lpe0, ld0, cnt0[e.ch*TW +: TW], lpe1, ld1, cnt1[e.ch*TW +: TW]},
              {e.cyc, e.ld ? 4'b0 : m, e.ld ? m : 4'b0, TW'(e.v0), e.ld ? 4'b0 : m, e.ld ? m : 4'b0, TW'(e.v1)});
        end
      end
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        d = dq.pop_front();
        chk("done_missing", 128'(cyc), 128'(d.cyc));
      end
      if (done0 || done1) begin
        if (dq.size() == 0) chk("done_unexpected", {done0, done1}, 0);
        else begin
          d = dq.pop_front();
          chk("done_cycle", 128'(cyc), 128'(d.cyc));
          chk("done_state", {done0, done1, sat0, sat1, err0, err1, busy0, busy1, tap0, tap1},
              {2'b11, d.s0, d.s1, d.e, d.e, 2'b11, d.t0, d.t1});
        end
      end
    end
  end
  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("reset_ctrl", {rdy0, done0, sat0, err0, busy0, lpe0, ld0, rdy1, done1, sat1, err1, busy1, lpe1, ld1}, 0);
    chk("reset_data", {tap0, cnt0, tap1, cnt1}, 0);
    dly_rdy = 1;
    ready_rise();
    issue(0, 2, 17, -1, 0);
    issue(0, 1, 28, -1, 0);
    issue(1, 1, 6, -1, 0);
    issue(0, 1, 3, -1, 1);
    issue(2, 1, 5, -1, 0);
    issue(3, 0, 9, -1, 0);
    issue(0, 3, 25, -1, 0);
    issue(3, 0, 20, 2, 0);
    issue(0, 0, 4, -1, 0);
    issue(1, 5, 3, -1, 1);
    issue(2, 6, 1, -1, 0);
    for (int i = 0; i < 40; i++)
      issue($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 31), -1, 1'($urandom_range(0, 1)));
    wait_ready();
    cmd_valid = 1;
    cmd_op = 0;
    cmd_ch = 3;
    cmd_val = 7;
    @(negedge clk);
    cmd_valid = 0;
    rst_n = 0;
    pin_q.delete();
    dq.delete();
    mt0 = '{default: 0};
    mt1 = '{default: 0};
    merr = 0;
    @(negedge clk);
    chk("reset_mid_ctrl", {rdy0, done0, sat0, err0, busy0, lpe0, ld0, rdy1, done1, sat1, err1, busy1, lpe1, ld1}, 0);
    chk("reset_mid_data", {tap0, cnt0, tap1, cnt1}, 0);
    rst_n = 1;
    ready_rise();
    issue(0, 1, 11, -1, 0);
    t = 0;
    while ((dq.size() > 0 || pin_q.size() > 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 128'(dq.size() + pin_q.size()), 0);
    chk("final_taps", {tap0, tap1}, {pack(mt0), pack(mt1)});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dyn_delay_ctrl.md
Name: dyn_delay_ctrl

Overview:
Parametrised multi-channel sequencer for IDELAYE2 primitives in VAR_LOAD_PIPE mode. It drives each channel's CNTVALUEIN, LDPIPEEN and LD pins from a command interface. Commands are load absolute, increment, decrement, or broadcast-load of all channels. It tracks a shadow tap per channel, gates all activity on IDELAYCTRL RDY, and holds off completion until the delay line has settled. It sits between the control register block and the delay instances that produce the skewed clocks.

Parameters:
N_CH, 4, number of delay channels (1-16)
TAP_W, 5, tap counter width (IDELAYE2 = 5)
SETTLE_CYC, 8, clk cycles to wait after the last LD before done (≥1)
WRAP, 0, 1 = INC/DEC wrap modulo 2^TAP_W; 0 = saturate at 0 / 2^TAP_W-1
CH_W, 2, channel index width, clog2(N_CH) (minimum 1)

Ports:
clk  in  1  system clock; also drives the IDELAYE2 C pin
rst_n  in  1  synchronous active-low reset
dly_rdy  in  1  IDELAYCTRL RDY, already synchronised to clk
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 LOAD_ALL
cmd_ch  in  CH_W  target channel; ignored for LOAD_ALL
cmd_val  in  TAP_W  absolute tap (LOAD/LOAD_ALL) or step (INC/DEC)
done  out  1  one-cycle pulse when a command completes
sat  out  1  valid with done: INC/DEC clamped (WRAP=0) or wrapped (WRAP=1)
err  out  1  sticky: dly_rdy dropped mid-command; cleared by reset or the next accepted command
busy  out  1  high in any state other than IDLE and WAIT_RDY
tap_cur  out  N_CH*TAP_W  shadow tap per channel; channel i occupies bits [i*TAP_W +: TAP_W]
idl_cntvalue  out  N_CH*TAP_W  to the CNTVALUEIN pins
idl_ldpipeen  out  N_CH  to the LDPIPEEN pins
idl_ld  out  N_CH  to the LD pins

Behaviour:
- Reset: state=WAIT_RDY. All outputs are 0: tap_cur, idl_cntvalue, idl_ld, idl_ldpipeen, done, sat, err, busy and cmd_ready.
- All outputs are registered. Only one channel's idl_ldpipeen/idl_ld bit is high in any cycle.
- WAIT_RDY: go to IDLE on the first cycle dly_rdy=1.
- IDLE:
  - cmd_ready=1; if dly_rdy=0, go to WAIT_RDY.
  - On accept: latch op/ch/val, clear err, compute new_tap, go to PIPE.
- new_tap is computed in TAP_W+1 bits:
  - LOAD: cmd_val.
  - INC: tap+val; on carry, WRAP ? low TAP_W bits : all-ones; sat=carry.
  - DEC: tap-val; on borrow, WRAP ? low TAP_W bits : 0; sat=borrow.
  - sat=0 for LOAD and LOAD_ALL.
  - cmd_ch ≥ N_CH (LOAD/INC/DEC): command is accepted, done pulses next cycle, no delay pins toggle, err is unchanged.
- PIPE (1 cycle): idl_cntvalue[ch]=new_tap and idl_ldpipeen[ch]=1. Go to LOAD.
- LOAD (1 cycle):
  - idl_ld[ch]=1, idl_cntvalue[ch] held, tap_cur[ch]=new_tap.
  - For LOAD_ALL, advance ch and return to PIPE until ch=N_CH-1; otherwise go to SETTLE.
- LOAD_ALL: channels are loaded in ascending order 0..N_CH-1, 2 cycles each, all with cmd_val.
- SETTLE: count SETTLE_CYC cycles, then go to DONE.
- DONE (1 cycle): done=1 and sat valid. Return to IDLE (cmd_ready=1 the following cycle).
- Latency: single-channel accept→done = 3+SETTLE_CYC cycles; LOAD_ALL = 2*N_CH+1+SETTLE_CYC cycles.
- idl_cntvalue holds its last value outside PIPE/LOAD. idl_ld and idl_ldpipeen are single-cycle pulses.
- dly_rdy=0 in PIPE/LOAD/SETTLE:
  - Abort: set err=1, go to WAIT_RDY, no done pulse.
  - tap_cur keeps only channels whose LOAD cycle completed.
  - The command is not retried.
- rst_n=0 mid-command: immediate return to reset values on the next clk edge. Pins deassert in that cycle.
- cmd_valid while busy is ignored (no queueing). The master holds cmd_valid until cmd_ready.

Test Plan:
- Reset with dly_rdy=0 for 10 cycles, then 1 → cmd_ready rises exactly 2 cycles after dly_rdy (WAIT_RDY→IDLE, registered); all pins and tap_cur stay 0.
- LOAD ch=2 val=17 → idl_ldpipeen[2] for 1 cycle with idl_cntvalue ch2=17, then idl_ld[2] for 1 cycle; tap_cur ch2=17; done 11 cycles after accept (SETTLE_CYC=8); sat=0.
- Starting from tap ch1=28: INC ch1 val=6 with WRAP=0 → tap 31, sat=1; with WRAP=1 → tap 2, sat=1. From tap 3: DEC val=5 with WRAP=0 → tap 0, sat=1.
- LOAD_ALL val=9 with N_CH=4 → LD pulses on ch0,1,2,3 at 2-cycle spacing, no overlap; all taps=9; done 17 cycles after accept.
- Drop dly_rdy during LOAD_ALL at ch2's PIPE → err=1, no done, taps ch0/ch1=new value, ch2/ch3 unchanged. Restore dly_rdy, issue LOAD ch0=4 → err clears on accept, completes normally.
- Assert cmd_valid while busy, and issue cmd_ch=5 with N_CH=4 → busy-time command not executed; invalid channel gives done with no pin activity and taps unchanged.
